n64_vbus_demux: RTL and testbench



---
 rtl/n64adv_vparams_pkg.sv | 32 +++
 rtl/n64_vtiming_detect.sv | 109 ++++++++++
 rtl/n64_vbus_demux.sv | 128 ++++++++++++
 tb/tb_n64_vbus_demux.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64adv_vparams_pkg.sv
// Shared video parameters for the N64 pixel-processing front end.
// Holds the sync-word bit layout, the colour component width, the default
// field-classification thresholds, the demux phase type and a small
// saturating-counter helper used by the timing detector.
package n64adv_vparams;

  // Bit positions inside the 4-bit sync word {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
  localparam int unsigned vsync = 3;
  localparam int unsigned clamp = 2;
  localparam int unsigned hsync = 1;
  localparam int unsigned csync = 0;

  localparam int unsigned color_width_i = 7;

  // Default line/pixel thresholds for field classification
  localparam int unsigned pal_line_thresh_def = 290;
  localparam int unsigned half_line_pix_def   = 386;
  localparam int unsigned lock_frames_def     = 2;

  // Demux phase: names the word latched on the current cycle
  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } vbus_phase_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/n64_vtiming_detect.sv
// Video timing detector for the demultiplexed N64 bus.
// Watches the sync word at each pixel strobe, counts pixels per line and
// lines per field, and classifies fields as PAL/NTSC and interlaced/
// progressive with a lock counter so the status only moves after a run of
// consistent fields.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   strobe        one-cycle pixel valid
//   sync_word     {nVSYNC,nCLAMP,nHSYNC,nCSYNC} of the strobed pixel
//   vsync_fall    combinational, high on the strobe carrying a VSYNC fall
//   palmode       1 = PAL line count
//   interlaced    1 = interlaced timing
//   field         current field ID (0 when progressive)
module n64_vtiming_detect
  import n64adv_vparams::*;
#(
  parameter int unsigned pal_line_thresh = pal_line_thresh_def,
  parameter int unsigned half_line_pix   = half_line_pix_def,
  parameter int unsigned lock_frames     = lock_frames_def
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [3:0] sync_word,
  output logic       vsync_fall,
  output logic       palmode,
  output logic       interlaced,
  output logic       field
);

  localparam int unsigned LOCK_W = $clog2(lock_frames + 1);

  logic              hs_prev;
  logic              vs_prev;
  logic              hsync_fall;
  logic [9:0]        pix_cnt;
  logic [9:0]        line_cnt;
  logic [9:0]        field_len;
  logic [9:0]        len_new;
  logic              pal_prev;
  logic              il_prev;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_next;
  logic              early;
  logic              pal_c;
  logic              il_c;
  logic              pal_next;
  logic              il_next;
  logic              unused_sync_bits;

  assign unused_sync_bits = sync_word[clamp] ^ sync_word[csync];

  assign hsync_fall = strobe & hs_prev & ~sync_word[hsync];
  assign vsync_fall = strobe & vs_prev & ~sync_word[vsync];

  always_comb begin
    // A coincident HSYNC fall counts its line before the field is captured
    len_new = hsync_fall ? sat_inc10(line_cnt) : line_cnt;
    early   = pix_cnt < 10'(half_line_pix);
    pal_c   = len_new >= 10'(pal_line_thresh);
    // 11-bit compare so 1023 vs 0 is not mistaken for a one-line step
    il_c    = ({1'b0, len_new} == {1'b0, field_len} + 11'd1) ||
              ({1'b0, field_len} == {1'b0, len_new} + 11'd1);
    if ({pal_c, il_c} == {pal_prev, il_prev})
      lock_next = (lock_cnt < LOCK_W'(lock_frames)) ? lock_cnt + LOCK_W'(1) : lock_cnt;
    else
      lock_next = LOCK_W'(1);
    pal_next = palmode;
    il_next  = interlaced;
    if (lock_next == LOCK_W'(lock_frames)) begin
      pal_next = pal_c;
      il_next  = il_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Previous sync levels start inactive (high), matching the idle bus
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      field_len  <= '0;
      pal_prev   <= 1'b0;
      il_prev    <= 1'b0;
      lock_cnt   <= '0;
      palmode    <= 1'b0;
      interlaced <= 1'b0;
      field      <= 1'b0;
    end else if (strobe) begin
      hs_prev <= sync_word[hsync];
      vs_prev <= sync_word[vsync];
      pix_cnt <= hsync_fall ? '0 : sat_inc10(pix_cnt);
      if (vsync_fall) begin
        line_cnt   <= '0;
        field_len  <= len_new;
        pal_prev   <= pal_c;
        il_prev    <= il_c;
        lock_cnt   <= lock_next;
        palmode    <= pal_next;
        interlaced <= il_next;
        field      <= il_next & il_c & ~early;
      end else if (hsync_fall) begin
        line_cnt <= len_new;
      end
    end
  end

endmodule

// File: rtl/n64_vbus_demux.sv
// First PPU stage: demultiplexes the registered N64 video bus into parallel
// {sync,R,G,B} pixel words with a one-cycle valid strobe, tracks bus-phase
// errors, and hosts the timing detector that derives PAL/interlace/field.
// Ports:
//   N64_CLK_i      N64 video clock
//   nRST_i         asynchronous active-low reset
//   nVDSYNC_i      low marks the sync word of a pixel group
//   VD_i           7-bit multiplexed video bus
//   vdata_valid_o  one-cycle strobe after a full group
//   vdata_sync_o   {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
//   vdata_r/g/b_o  colour components
//   palmode_o, interlaced_o, field_o  timing status
//   phase_err_o    sticky nVDSYNC spacing error
module n64_vbus_demux
  import n64adv_vparams::*;
#(
  parameter int unsigned pal_line_thresh = pal_line_thresh_def,
  parameter int unsigned half_line_pix   = half_line_pix_def,
  parameter int unsigned lock_frames     = lock_frames_def
) (
  input  logic                     N64_CLK_i,
  input  logic                     nRST_i,
  input  logic                     nVDSYNC_i,
  input  logic [color_width_i-1:0] VD_i,
  output logic                     vdata_valid_o,
  output logic [3:0]               vdata_sync_o,
  output logic [color_width_i-1:0] vdata_r_o,
  output logic [color_width_i-1:0] vdata_g_o,
  output logic [color_width_i-1:0] vdata_b_o,
  output logic                     palmode_o,
  output logic                     interlaced_o,
  output logic                     field_o,
  output logic                     phase_err_o
);

  vbus_phase_e              phase;
  logic [3:0]               sh_sync;
  logic [color_width_i-1:0] sh_r;
  logic [color_width_i-1:0] sh_g;
  logic                     b_latched;
  logic                     overrun_chk;
  logic                     field_clean;
  logic                     vsync_fall;

  always_ff @(posedge N64_CLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      // Idle in B so the first nVDSYNC low after reset is not flagged short
      phase         <= PH_B;
      sh_sync       <= '1;
      sh_r          <= '0;
      sh_g          <= '0;
      b_latched     <= 1'b0;
      overrun_chk   <= 1'b0;
      field_clean   <= 1'b0;
      vdata_valid_o <= 1'b0;
      vdata_sync_o  <= '1;
      vdata_r_o     <= '0;
      vdata_g_o     <= '0;
      vdata_b_o     <= '0;
      phase_err_o   <= 1'b0;
    end else begin
      b_latched     <= 1'b0;
      vdata_valid_o <= b_latched;

      if (vsync_fall) begin
        if (field_clean)
          phase_err_o <= 1'b0;
        field_clean <= 1'b1;
      end

      // Error updates come after the VSYNC handling so a same-cycle error wins
      if (!nVDSYNC_i) begin
        if (phase != PH_B) begin
          phase_err_o <= 1'b1;
          field_clean <= 1'b0;
        end
        phase       <= PH_SYNC;
        sh_sync     <= VD_i[3:0];
        overrun_chk <= 1'b0;
      end else begin
        case (phase)
          PH_SYNC: begin
            phase <= PH_R;
            sh_r  <= VD_i;
          end
          PH_R: begin
            phase <= PH_G;
            sh_g  <= VD_i;
          end
          PH_G: begin
            // B goes straight to the output register; it is its own shadow
            phase        <= PH_B;
            vdata_sync_o <= sh_sync;
            vdata_r_o    <= sh_r;
            vdata_g_o    <= sh_g;
            vdata_b_o    <= VD_i;
            b_latched    <= 1'b1;
            overrun_chk  <= 1'b1;
          end
          PH_B: begin
            // Overrun flagged once per group; armed only by a real B latch
            if (overrun_chk) begin
              phase_err_o <= 1'b1;
              field_clean <= 1'b0;
              overrun_chk <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  n64_vtiming_detect #(
    .pal_line_thresh(pal_line_thresh),
    .half_line_pix  (half_line_pix),
    .lock_frames    (lock_frames)
  ) u_timing (
    .clk       (N64_CLK_i),
    .rst_n     (nRST_i),
    .strobe    (vdata_valid_o),
    .sync_word (vdata_sync_o),
    .vsync_fall(vsync_fall),
    .palmode   (palmode_o),
    .interlaced(interlaced_o),
    .field     (field_o)
  );

endmodule

// File: tb/tb_n64_vbus_demux.sv
module tb_n64_vbus_demux;

  localparam int unsigned PAL_THR  = 290;
  localparam int unsigned HALF_PIX = 386;
  localparam int unsigned LOCK_N   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nvdsync = 1'b1;
  logic [6:0] vd = '0;
  logic       valid;
  logic [3:0] sync;
  logic [6:0] r, g, b;
  logic       pal, il, fld, perr;

  n64_vbus_demux #(
    .pal_line_thresh(PAL_THR),
    .half_line_pix  (HALF_PIX),
    .lock_frames    (LOCK_N)
  ) dut (
    .N64_CLK_i    (clk),
    .nRST_i       (rst_n),
    .nVDSYNC_i    (nvdsync),
    .VD_i         (vd),
    .vdata_valid_o(valid),
    .vdata_sync_o (sync),
    .vdata_r_o    (r),
    .vdata_g_o    (g),
    .vdata_b_o    (b),
    .palmode_o    (pal),
    .interlaced_o (il),
    .field_o      (fld),
    .phase_err_o  (perr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]  s;
    logic [6:0]  r, g, b;
    int unsigned t0;
  } exp_t;
  exp_t sb[$];

  // ---------------- timing model ----------------
  bit          m_hs, m_vs, m_pc, m_ic, m_pal, m_il, m_fld;
  int unsigned m_pix, m_line, m_flen, m_lock;
  bit          stat_pending;

  function automatic void model_reset();
    m_hs = 1; m_vs = 1; m_pc = 0; m_ic = 0; m_pal = 0; m_il = 0; m_fld = 0;
    m_pix = 0; m_line = 0; m_flen = 0; m_lock = 0; stat_pending = 0;
  endfunction

  function automatic bit model_step(input logic [3:0] s);
    bit hf, vf, early, pc, ic, fc;
    int unsigned len;
    hf = m_hs && !s[1];
    vf = m_vs && !s[3];
    if (vf) begin
      len = m_line + (hf ? 1 : 0);
      if (len > 1023) len = 1023;
      early = m_pix < HALF_PIX;
      pc = len >= PAL_THR;
      ic = (len == m_flen + 1) || (m_flen == len + 1);
      fc = ic && !early;
      if (pc == m_pc && ic == m_ic) begin
        if (m_lock < LOCK_N) m_lock++;
      end else m_lock = 1;
      m_pc = pc; m_ic = ic; m_flen = len;
      if (m_lock == LOCK_N) begin m_pal = pc; m_il = ic; end
      m_fld = m_il && fc;
      m_line = 0;
    end else if (hf && m_line < 1023) m_line++;
    if (hf) m_pix = 0;
    else if (m_pix < 1023) m_pix++;
    m_hs = s[1];
    m_vs = s[3];
    return vf;
  endfunction

  // ---------------- monitor ----------------
  exp_t mon_e;
  bit   mon_have;
  always @(negedge clk) begin
    if (rst_n && valid) begin
      mon_have = (sb.size() != 0);
      chk("strobe_expected", mon_have, 1);
      if (mon_have) begin
        mon_e = sb.pop_front();
        chk("sync", sync, mon_e.s);
        chk("red", r, mon_e.r);
        chk("green", g, mon_e.g);
        chk("blue", b, mon_e.b);
        chk("latency", cyc - mon_e.t0, 4);
        if (stat_pending) begin
          chk("palmode_model", pal, m_pal);
          chk("interlaced_model", il, m_il);
          chk("field_model", fld, m_fld);
        end
        stat_pending = model_step(mon_e.s);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive_cycle(input logic nv, input logic [6:0] d);
    nvdsync = nv;
    vd = d;
    @(negedge clk);
  endtask

  task automatic send_group(input logic [6:0] vs, input logic [6:0] rr, input logic [6:0] gg,
                            input logic [6:0] bb, input logic [3:0] es, input logic [6:0] er,
                            input logic [6:0] eg, input logic [6:0] eb);
    exp_t e;
    e.s = es; e.r = er; e.g = eg; e.b = eb; e.t0 = cyc + 1;
    sb.push_back(e);
    drive_cycle(1'b0, vs);
    drive_cycle(1'b1, rr);
    drive_cycle(1'b1, gg);
    drive_cycle(1'b1, bb);
  endtask

  task automatic send_word(input logic [3:0] s);
    logic [6:0] rr, gg, bb;
    logic [2:0] junk;
    rr = 7'($urandom); gg = 7'($urandom); bb = 7'($urandom); junk = 3'($urandom);
    send_group({junk, s}, rr, gg, bb, s, rr, gg, bb);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b1, 7'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nvdsync = 1'b1;
    vd = '0;
    repeat (2) @(negedge clk);
    sb.delete();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // lines: each one an HSYNC-high word then an HSYNC fall; vpix pixels then VSYNC fall
  task automatic send_field(input int lines, input int vpix);
    for (int i = 0; i < lines; i++) begin
      send_word(4'hF);
      send_word(4'hD);
    end
    repeat (vpix) send_word(4'hF);
    send_word(4'h7);
    send_word(4'hF);
    send_word(4'hF);
  endtask

  task automatic chk_status(input string tag, input bit ep, input bit ei, input bit ef);
    chk({tag, "_palmode"}, pal, ep);
    chk({tag, "_interlaced"}, il, ei);
    chk({tag, "_field"}, fld, ef);
  endtask

  typedef struct {
    logic [6:0] vs, rr, gg, bb;
    logic [3:0] es;
    logic [6:0] er, eg, eb;
  } vec_t;
  vec_t vec [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{7'h0F, 7'h11, 7'h22, 7'h33, 4'hF, 7'h11, 7'h22, 7'h33};
    vec[1] = '{7'h0F, 7'h11, 7'h22, 7'h33, 4'hF, 7'h11, 7'h22, 7'h33};
    vec[2] = '{7'h0F, 7'h11, 7'h22, 7'h33, 4'hF, 7'h11, 7'h22, 7'h33};
    vec[3] = '{7'h7F, 7'h7F, 7'h00, 7'h55, 4'hF, 7'h7F, 7'h00, 7'h55};
    vec[4] = '{7'h3E, 7'h2A, 7'h15, 7'h7F, 4'hE, 7'h2A, 7'h15, 7'h7F};
    vec[5] = '{7'h0B, 7'h01, 7'h40, 7'h3C, 4'hB, 7'h01, 7'h40, 7'h3C};
    vec[6] = '{7'h50, 7'h7E, 7'h3D, 7'h02, 4'h0, 7'h7E, 7'h3D, 7'h02};
    vec[7] = '{7'h0F, 7'h00, 7'h00, 7'h00, 4'hF, 7'h00, 7'h00, 7'h00};
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_sync", sync, 4'hF);
    chk("rst_red", r, 0);
    chk("rst_green", g, 0);
    chk("rst_blue", b, 0);
    chk("rst_status", {pal, il, fld}, 3'b000);
    chk("rst_phase_err", perr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal table, back-to-back groups, then idle (overrun after last B)
    for (int i = 0; i < 8; i++)
      send_group(vec[i].vs, vec[i].rr, vec[i].gg, vec[i].bb,
                 vec[i].es, vec[i].er, vec[i].eg, vec[i].eb);
    chk("table_no_err", perr, 0);
    idle(8);
    chk("table_drained", sb.size(), 0);
    chk("overrun_err", perr, 1);

    // Short group and sticky phase error across fields
    do_reset();
    send_word(4'hF);
    send_word(4'hF);
    chk("short_pre_err", perr, 0);
    drive_cycle(1'b0, 7'h0F);
    drive_cycle(1'b1, 7'h44);
    send_word(4'hF);
    chk("short_err_set", perr, 1);
    send_word(4'h7);
    send_word(4'hF);
    send_word(4'hF);
    chk("short_err_held", perr, 1);
    send_word(4'h7);
    send_word(4'hF);
    send_word(4'hF);
    chk("short_err_cleared", perr, 0);
    idle(8);
    chk("short_drained", sb.size(), 0);

    // Async reset in state G
    do_reset();
    send_group(7'h0F, 7'h5A, 7'h25, 7'h6B, 4'hF, 7'h5A, 7'h25, 7'h6B);
    drive_cycle(1'b0, 7'h03);
    drive_cycle(1'b1, 7'h11);
    drive_cycle(1'b1, 7'h22);
    chk("pre_reset_red", r, 7'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", valid, 0);
    chk("async_sync", sync, 4'hF);
    chk("async_rgb", {r, g, b}, 21'h0);
    chk("async_perr", perr, 0);
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("post_reset_no_err", perr, 0);
    chk("post_reset_no_strobe", valid, 0);
    send_group(7'h0C, 7'h12, 7'h34, 7'h56, 4'hC, 7'h12, 7'h34, 7'h56);
    idle(6);
    chk("post_reset_drained", sb.size(), 0);

    // PAL interlaced then NTSC progressive
    do_reset();
    send_field(312, 100);
    chk_status("pal_f1", 0, 0, 0);
    send_field(313, 500);
    send_field(312, 500);
    chk_status("pal_f3", 1, 1, 1);
    send_field(313, 100);
    chk_status("pal_f4", 1, 1, 0);
    send_field(312, 500);
    chk_status("pal_f5", 1, 1, 1);
    send_field(263, 100);
    chk_status("ntsc_f1", 1, 1, 0);
    send_field(263, 500);
    chk_status("ntsc_f2", 0, 0, 0);
    send_field(263, 500);
    chk_status("ntsc_f3", 0, 0, 0);
    chk("fields_no_err", perr, 0);

    // Simultaneous HSYNC and VSYNC fall after 262 lines
    do_reset();
    for (int i = 0; i < 262; i++) begin
      send_word(4'hF);
      send_word(4'hD);
    end
    send_word(4'hF);
    send_word(4'h5);
    send_word(4'hF);
    send_word(4'hF);
    chk("simul_field_len", 32'(dut.u_timing.field_len), 263);
    chk("simul_line_cnt", 32'(dut.u_timing.line_cnt), 0);
    idle(8);
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
